// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
// Requester indices double as response-channel indices (owner = index + 1).
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam int NUM_REQ = 3;
  localparam int REQ_IF  = 0;
  localparam int REQ_DM  = 1;
  localparam int REQ_DBG = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  function automatic owner_e chan_owner(input int idx);
    return owner_e'(2'(idx + 1));
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority picker: DM > promoted debug > IF > debug.
// Returns a one-hot (or all-zero) grant vector indexed by REQ_*.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               promote,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[REQ_DM])                    gnt[REQ_DM]  = 1'b1;
    else if (promote && req[REQ_DBG])   gnt[REQ_DBG] = 1'b1;
    else if (req[REQ_IF])               gnt[REQ_IF]  = 1'b1;
    else if (req[REQ_DBG])              gnt[REQ_DBG] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch, data and debug.
// Define MEM_ARB_PERF_EN to add saturating conflict / fetch-stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DBG_AW     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  input  logic              dbg_req,
  input  logic [DBG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_if_stall_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  owner_e                          owner_q, owner_d;
  logic [SW-1:0]                   starve_cnt;
  logic [NUM_REQ-1:0]              req, gnt, rsp_vld;
  logic [NUM_REQ-1:0][DATA_W-1:0]  rdata_out;
  logic                            dm_req, dbg_live, promote;

  assign dm_req = dm_rd | dm_wr;
  // A held debug request is not re-armed while its own response is in flight,
  // so the level handshake cannot trigger a duplicate read.
  assign dbg_live = dbg_req & (owner_q != OWN_DBG);
  assign promote  = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    req          = '0;
    req[REQ_IF]  = if_req;
    req[REQ_DM]  = dm_req;
    req[REQ_DBG] = dbg_live;
  end

  mem_arb_prio u_prio (
    .req     (req),
    .promote (promote),
    .gnt     (gnt)
  );

  always_comb begin
    mem_en    = |gnt;
    mem_we    = gnt[REQ_DM] & dm_wr;
    mem_wdata = dm_wdata;
    mem_addr  = '0;
    owner_d   = OWN_NONE;
    if (gnt[REQ_DM]) begin
      mem_addr = dm_addr[ADDR_W+1:2];
      owner_d  = dm_wr ? OWN_NONE : OWN_DM;
    end else if (gnt[REQ_IF]) begin
      mem_addr = if_addr[ADDR_W+1:2];
      owner_d  = OWN_IF;
    end else if (gnt[REQ_DBG]) begin
      mem_addr = ADDR_W'(dbg_addr);
      owner_d  = OWN_DBG;
    end
  end

  assign if_gnt   = gnt[REQ_IF];
  assign stall_if = if_req & ~gnt[REQ_IF];

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner_q <= owner_d;
      if (!dbg_live || gnt[REQ_DBG])
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Each channel shows mem_rdata in its valid cycle and holds it afterwards.
  for (genvar ch = 0; ch < NUM_REQ; ch++) begin : g_rsp
    logic [DATA_W-1:0] hold_q;
    assign rsp_vld[ch]   = ~rst && (owner_q == chan_owner(ch));
    assign rdata_out[ch] = rsp_vld[ch] ? mem_rdata : hold_q;
    always_ff @(posedge clk) begin
      if (rst)              hold_q <= '0;
      else if (rsp_vld[ch]) hold_q <= mem_rdata;
    end
  end

  assign if_valid  = rsp_vld[REQ_IF];
  assign dm_valid  = rsp_vld[REQ_DM];
  assign dbg_valid = rsp_vld[REQ_DBG];
  assign if_rdata  = rdata_out[REQ_IF];
  assign dm_rdata  = rdata_out[REQ_DM];
  assign dbg_rdata = rdata_out[REQ_DBG];

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_if_stall_cnt <= '0;
    end else begin
      if (conflict && !(&perf_conflict_cnt)) perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
      if (stall_if && !(&perf_if_stall_cnt)) perf_if_stall_cnt <= perf_if_stall_cnt + 1'b1;
    end
  end
`endif

  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         dm_addr[31:ADDR_W+2], dm_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory macro.
// Grants are checked per cycle; read responses are queued and matched in order.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 8, DATA_W = 32, DBG_AW = 6, STARVE_MAX = 4;

  logic              clk, rst;
  logic              if_req, if_gnt, if_valid, stall_if;
  logic [31:0]       if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_rd, dm_wr, dm_valid;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              dbg_req, dbg_valid;
  logic [DBG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_conflict_cnt, perf_if_stall_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBG_AW(DBG_AW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_if_stall_cnt(perf_if_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory macro and the bench's independent image of its contents
  logic [DATA_W-1:0] mem    [0:255];
  logic [DATA_W-1:0] shadow [0:255];

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end

  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    owner_e      own;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Checks one cycle's grant against the expected owner, then advances.
  task automatic step(input owner_e own, input logic we, input logic [7:0] addr);
    rsp_t r;
    @(negedge clk);
    chk("mem_en",   mem_en,   own != OWN_NONE);
    chk("mem_we",   mem_we,   we);
    chk("if_gnt",   if_gnt,   own == OWN_IF);
    chk("stall_if", stall_if, if_req && (own != OWN_IF));
    if (own != OWN_NONE) chk("mem_addr", mem_addr, addr);
    if (we) begin
      chk("mem_wdata", mem_wdata, dm_wdata);
      shadow[addr] = dm_wdata;
    end else if (own != OWN_NONE) begin
      r.own  = own;
      r.data = shadow[addr];
      r.due  = cyc + 1;
      sb.push_back(r);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon
    rsp_t        r;
    logic [2:0]  ev;
    logic [31:0] ed;
    ev = '0;
    ed = '0;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      r = sb.pop_front();
      chk("rsp_due", cyc, r.due);
      ev = (r.own == OWN_IF) ? 3'b100 : (r.own == OWN_DM) ? 3'b010 : 3'b001;
      ed = r.data;
    end
    chk("valids", {if_valid, dm_valid, dbg_valid}, ev);
    if (ev[2]) chk("if_rdata",  if_rdata,  ed);
    if (ev[1]) chk("dm_rdata",  dm_rdata,  ed);
    if (ev[0]) chk("dbg_rdata", dbg_rdata, ed);
  end

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    dbg_req = 0; dbg_addr = '0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h1000_0000 + i * 32'h0101;
      shadow[i] = 32'h1000_0000 + i * 32'h0101;
    end
    mem[4]    = 32'h8C01_0004;
    shadow[4] = 32'h8C01_0004;

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_if_rdata",  if_rdata,  0);
    chk("rst_dm_rdata",  dm_rdata,  0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IF-only read
    if_req = 1; if_addr = 32'h10;
    step(OWN_IF, 0, 8'd4);
    if_req = 0;
    step(OWN_NONE, 0, 8'd0);

    // IF vs DM load: DM first, IF next, responses in grant order
    if_req = 1; if_addr = 32'h10; dm_rd = 1; dm_addr = 32'h20;
    step(OWN_DM, 0, 8'd8);
    dm_rd = 0;
    step(OWN_IF, 0, 8'd4);
    if_req = 0;
    step(OWN_NONE, 0, 8'd0);

    // store, then debug readback with request held through dbg_valid
    dm_wr = 1; dm_addr = 32'h24; dm_wdata = 32'hDEAD_BEEF;
    step(OWN_DM, 1, 8'd9);
    dm_wr = 0;
    step(OWN_NONE, 0, 8'd0);
    dbg_req = 1; dbg_addr = 6'd9;
    step(OWN_DBG, 0, 8'd9);
    step(OWN_NONE, 0, 8'd0);
    dbg_req = 0;
    step(OWN_NONE, 0, 8'd0);

    // rd+wr together is a store
    dm_rd = 1; dm_wr = 1; dm_addr = 32'h28; dm_wdata = 32'h1234_5678;
    step(OWN_DM, 1, 8'd10);
    dm_wr = 0;
    step(OWN_DM, 0, 8'd10);
    dm_rd = 0;
    step(OWN_NONE, 0, 8'd0);

    // debug starvation and promotion
    if_req = 1; if_addr = 32'h10; dbg_req = 1; dbg_addr = 6'd5;
    repeat (4) step(OWN_IF, 0, 8'd4);
    step(OWN_DBG, 0, 8'd5);
    step(OWN_IF, 0, 8'd4);
    dbg_req = 0;
    step(OWN_IF, 0, 8'd4);
    // counter restarted from zero; DM still beats a promoted debug
    dbg_req = 1; dbg_addr = 6'd63;
    repeat (4) step(OWN_IF, 0, 8'd4);
    dm_rd = 1; dm_addr = 32'h30;
    step(OWN_DM, 0, 8'd12);
    dm_rd = 0;
    step(OWN_DBG, 0, 8'd63);
    step(OWN_IF, 0, 8'd4);
    dbg_req = 0; if_req = 0;
    step(OWN_NONE, 0, 8'd0);

    // upper byte-address bits ignored
    if_req = 1; if_addr = 32'hFFFF_FC08;
    step(OWN_IF, 0, 8'd2);
    if_req = 0;
    step(OWN_NONE, 0, 8'd0);

    // reset with an IF response in flight: the pulse is dropped
    if_req = 1; if_addr = 32'h10;
    step(OWN_IF, 0, 8'd4);
    if_req = 0; rst = 1;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_if_rdata",  if_rdata,  0);
    chk("post_rst_dm_rdata",  dm_rdata,  0);
    chk("post_rst_dbg_rdata", dbg_rdata, 0);
    @(posedge clk); #1;

`ifdef MEM_ARB_PERF_EN
    if_req = 1; if_addr = 32'h10; dm_rd = 1; dm_addr = 32'h20;
    repeat (3) step(OWN_DM, 0, 8'd8);
    dm_rd = 0; if_req = 0;
    step(OWN_NONE, 0, 8'd0);
    chk("perf_conflict", perf_conflict_cnt, 3);
    chk("perf_stall",    perf_if_stall_cnt, 3);
`endif

    repeat (2) step(OWN_NONE, 0, 8'd0);
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between three requesters: instruction fetch (IF), data load/store (DM) and the external debug read port.
- Sits between the pipeline register/PC logic and the memory macro.
- Grants at most one access per cycle and returns read data one cycle later with a valid strobe.
- Drives a fetch-stall signal so the PC holds while fetch is locked out.

Parameters:
- ADDR_W, 8, word-address width of the memory macro.
- DATA_W, 32, data width.
- DBG_AW, 6, debug read address width (word address).
- STARVE_MAX, 4, consecutive denied debug cycles before debug is promoted above IF.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  if_rdata valid (one-cycle pulse).
- stall_if  out  1  if_req & ~if_gnt; holds PC and IF/ID register.
- dm_rd  in  1  data load request.
- dm_wr  in  1  data store request.
- dm_addr  in  32  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  dm_rdata valid pulse.
- dbg_req  in  1  debug read request; level, held until dbg_valid.
- dbg_addr  in  DBG_AW  debug word address.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_valid  out  1  debug data valid pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Reset (rst=1 at a clock edge):
  - owner register = NONE; starve counter = 0.
  - if_valid, dm_valid and dbg_valid = 0; all rdata outputs = 0.
  - A response in flight at reset is dropped: no valid pulse follows.
- Selection, combinational each cycle:
  - Priority: DM (dm_rd|dm_wr) > promoted debug > IF > debug.
  - Debug is promoted when starve_cnt == STARVE_MAX.
  - Debug is never promoted above DM.
- Address mapping:
  - IF and DM use byte address bits [ADDR_W+1:2]; upper bits are ignored.
  - dbg_addr is zero-extended to ADDR_W, or truncated if DBG_AW > ADDR_W.
- Store vs load: dm_wr and dm_rd together is treated as a store.
  - A store drives mem_we=1, mem_wdata=dm_wdata and produces no valid pulse.
- Owner register:
  - Loaded at each edge with the requester granted for a read (IF, DM, DBG) or NONE (idle or store).
  - Next cycle: mem_rdata is registered into the owner's rdata output and the matching valid pulses for 1 cycle.
  - Read latency is fixed at 1 cycle after grant.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each cycle dbg_req=1 and debug is not granted.
  - Clears on a debug grant or when dbg_req=0.
- Fetch handling:
  - stall_if=1 whenever IF loses arbitration.
  - if_addr must stay stable while stalled.
- Back-to-back grants to different owners are allowed every cycle; responses stay in grant order.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_conflict_cnt [31:0]: counts cycles with ≥2 simultaneous requesters.
  - Adds output perf_if_stall_cnt [31:0]: counts stall_if cycles.
  - Both counters are cleared by rst and saturate at all-ones.
- Undefined: the ports and counters do not exist; arbitration is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - owner enum {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG}.
  - Default widths ADDR_W/DATA_W.
- Sub-module mem_arb_prio: purely combinational priority picker taking the request vector and the promote flag, returning a one-hot grant.
- The top module holds the owner register, starve counter and response registers.

Test Plan:
- Reset then IF-only read: if_req=1, if_addr=0x10, mem word 4 = 0x8C010004 → if_gnt=1 at cycle 0; if_valid=1 with if_rdata=0x8C010004 at cycle 1; stall_if=0.
- IF and DM load in the same cycle, dm_addr=0x20 → DM granted (mem_addr=8) and stall_if=1; IF granted next cycle; dm_valid then if_valid on consecutive cycles.
- Store: dm_wr=1, dm_addr=0x24, dm_wdata=0xDEADBEEF → mem_we=1, mem_addr=9, no valid pulse; a later debug read of address 9 returns 0xDEADBEEF.
- Debug starvation: dbg_req=1 and if_req=1 held continuously, STARVE_MAX=4 → IF granted 4 cycles, debug granted on the 5th, dbg_valid on the 6th, counter cleared.
- rst asserted the cycle after an IF grant → no if_valid pulse; owner=NONE; all valids 0.
- MEM_ARB_PERF_EN: 3 IF+DM conflict cycles → perf_conflict_cnt=3 and perf_if_stall_cnt=3.
